// File: rtl/ex_alu_stage_if.sv
// ID/EX -> EX bus for the execute stage: buffered instruction fields in, registered results out.
// VALID_IN/STALL: an instruction is taken on a rising edge where VALID_IN=1, STALL=0 and FLUSH=0; while STALL is high the producer holds its fields steady, and VALID_OUT is a one-cycle pulse marking a fresh result.
interface ex_alu_stage_if #(parameter int WIDTH = 16);
  logic             VALID_IN;
  logic             FLUSH;
  logic [WIDTH-1:0] FUNC_CODE;
  logic [WIDTH-1:0] EXECUTION;
  logic [WIDTH-1:0] VALUE1;
  logic [WIDTH-1:0] VALUE2;
  logic [WIDTH-1:0] IMMEDIATE;
  logic [WIDTH-1:0] OP1_ADDRESS;
  logic [WIDTH-1:0] PROGRAM_COUNTER;
  logic [WIDTH-1:0] RESULT;
  logic [WIDTH-1:0] RESULT_HI;
  logic [3:0]       FLAGS;
  logic [WIDTH-1:0] DEST_OUT;
  logic [WIDTH-1:0] PC_OUT;
  logic             VALID_OUT;
  logic             STALL;

  modport master (
    output VALID_IN, FLUSH, FUNC_CODE, EXECUTION, VALUE1, VALUE2, IMMEDIATE,
           OP1_ADDRESS, PROGRAM_COUNTER,
    input  RESULT, RESULT_HI, FLAGS, DEST_OUT, PC_OUT, VALID_OUT, STALL
  );

  modport slave (
    input  VALID_IN, FLUSH, FUNC_CODE, EXECUTION, VALUE1, VALUE2, IMMEDIATE,
           OP1_ADDRESS, PROGRAM_COUNTER,
    output RESULT, RESULT_HI, FLAGS, DEST_OUT, PC_OUT, VALID_OUT, STALL
  );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute stage: single-cycle ALU plus iterative unsigned multiply (shift-add) and divide (restoring).
// Results are registered toward EX/MEM; STALL holds ID/EX while a multi-cycle op is in flight.
module ex_alu_stage #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic         CLK,
  input  logic         RST,
  ex_alu_stage_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opb_q, opb_d;
  logic [WIDTH-1:0] dest_q, dest_d, pc_q, pc_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] dest_out_q, dest_out_d, pc_out_q, pc_out_d;
  logic             valid_out_q, valid_out_d, stall_q, stall_d;

  logic [3:0]       op, sh;
  logic [WIDTH-1:0] a, b;
  logic             accept;
  logic [WIDTH:0]   sum_w, dif_w;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic             unused_ok;

  assign op     = bus.FUNC_CODE[3:0];
  assign a      = bus.VALUE1;
  assign b      = bus.EXECUTION[0] ? bus.IMMEDIATE : bus.VALUE2;
  assign sh     = b[3:0];
  assign accept = bus.VALID_IN & ~stall_q & ~bus.FLUSH;
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign dif_w  = {1'b0, a} - {1'b0, b};
  assign rol_w  = {a, a} << sh;
  assign ror_w  = {a, a} >> sh;

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = dif_w[WIDTH-1:0];
        alu_c   = dif_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = a ^ b;
      4'd5:  alu_res = ~a;
      4'd6:  alu_res = a << sh;
      4'd7:  alu_res = a >> sh;
      4'd8:  alu_res = $signed(a) >>> sh;
      4'd9:  alu_res = rol_w[2*WIDTH-1:WIDTH];
      4'd10: alu_res = ror_w[WIDTH-1:0];
      // Only the zero-divisor case of DIV completes in the single-cycle path.
      4'd12: begin
        alu_res = '1;
        alu_hi  = a;
        alu_v   = 1'b1;
      end
      4'd13: alu_res = b;
      4'd14: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One iteration step: lo_q holds multiplier / dividend-quotient, opb_q multiplicand / divisor.
  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi   = mul_sum[WIDTH:1];
  assign mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign div_sh   = {acc_q, lo_q[WIDTH-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, opb_q};
  assign div_ok   = ~div_diff[WIDTH+1];
  assign div_hi   = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo   = {lo_q[WIDTH-2:0], div_ok};

  assign unused_ok = ^{bus.FUNC_CODE[WIDTH-1:4], bus.EXECUTION[WIDTH-1:1],
                       rol_w[WIDTH-1:0], ror_w[2*WIDTH-1:WIDTH], div_diff[WIDTH], div_sh[WIDTH]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opb_d       = opb_q;
    dest_d      = dest_q;
    pc_d        = pc_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    dest_out_d  = dest_out_q;
    pc_out_d    = pc_out_q;
    valid_out_d = 1'b0;
    stall_d     = stall_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == 4'd11 || (op == 4'd12 && b != '0)) begin
            state_d = (op == 4'd11) ? S_MUL : S_DIV;
            stall_d = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = a;
            opb_d   = b;
            dest_d  = bus.OP1_ADDRESS;
            pc_d    = bus.PROGRAM_COUNTER;
          end else begin
            result_d    = alu_res;
            result_hi_d = alu_hi;
            flags_d     = {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
            dest_out_d  = bus.OP1_ADDRESS;
            pc_out_d    = bus.PROGRAM_COUNTER;
            valid_out_d = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (bus.FLUSH) begin
          state_d = S_IDLE;
          stall_d = 1'b0;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_hi : div_hi;
          lo_d  = (state_q == S_MUL) ? mul_lo : div_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_d     = S_IDLE;
            stall_d     = 1'b0;
            result_d    = lo_d;
            result_hi_d = acc_d;
            flags_d     = (state_q == S_MUL)
                        ? {lo_d == '0, lo_d[WIDTH-1], acc_d != '0, acc_d != '0}
                        : {lo_d == '0, lo_d[WIDTH-1], 2'b00};
            dest_out_d  = dest_q;
            pc_out_d    = pc_q;
            valid_out_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      dest_q      <= '0;
      pc_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      dest_out_q  <= '0;
      pc_out_q    <= '0;
      valid_out_q <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      dest_q      <= dest_d;
      pc_q        <= pc_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      dest_out_q  <= dest_out_d;
      pc_out_q    <= pc_out_d;
      valid_out_q <= valid_out_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.RESULT    = result_q;
  assign bus.RESULT_HI = result_hi_q;
  assign bus.FLAGS     = flags_q;
  assign bus.DEST_OUT  = dest_out_q;
  assign bus.PC_OUT    = pc_out_q;
  assign bus.VALID_OUT = valid_out_q;
  assign bus.STALL     = stall_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: reference model feeds an expected-result queue, a monitor pops on VALID_OUT.
module tb_ex_alu_stage;
  logic       CLK;
  logic       RST;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  logic [67:0] exp_q[$];

  ex_alu_stage_if #(.WIDTH(16)) bus ();

  ex_alu_stage #(.WIDTH(16), .ITER(16)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: {result, result_hi, flags}
  function automatic logic [35:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r, h;
    logic        c, v;
    logic [31:0] p, dd;
    int          sa;
    r = 16'h0; h = 16'h0; c = 1'b0; v = 1'b0;
    dd = {a, a};
    sa = $signed(a);
    case (op)
      4'd0: begin r = a + b; c = (32'(a) + 32'(b)) > 32'hFFFF; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << b[3:0];
      4'd7: r = a >> b[3:0];
      4'd8: begin sa = sa >>> b[3:0]; r = sa[15:0]; end
      4'd9: begin p = dd << b[3:0]; r = p[31:16]; end
      4'd10: begin p = dd >> b[3:0]; r = p[15:0]; end
      4'd11: begin p = 32'(a) * 32'(b); r = p[15:0]; h = p[31:16]; c = (h != 0); v = c; end
      4'd12: if (b == 0) begin r = 16'hFFFF; h = a; v = 1'b1; end
             else begin r = a / b; h = a % b; end
      4'd13: r = b;
      4'd14: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: r = 16'h0;
    endcase
    return {r, h, (r == 0), r[15], c, v};
  endfunction

  // driver tasks
  task automatic drive(input logic [3:0] op, input logic ex, input logic [15:0] a, input logic [15:0] v2,
                       input logic [15:0] imm, input logic [15:0] dest, input logic [15:0] pc, input bit push);
    logic [15:0] b;
    bus.VALID_IN        = 1'b1;
    bus.FLUSH           = 1'b0;
    bus.FUNC_CODE       = {12'h0, op};
    bus.EXECUTION       = {15'h0, ex};
    bus.VALUE1          = a;
    bus.VALUE2          = v2;
    bus.IMMEDIATE       = imm;
    bus.OP1_ADDRESS     = dest;
    bus.PROGRAM_COUNTER = pc;
    b = ex ? imm : v2;
    if (push) exp_q.push_back({model(op, a, b), dest, pc});
  endtask

  task automatic idle();
    bus.VALID_IN = 1'b0;
    bus.FLUSH    = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    while (bus.STALL === 1'b1 && n < 40) begin
      check("busy_no_valid", {71'h0, bus.VALID_OUT}, 72'h0);
      n++;
      @(negedge CLK);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (RST === 1'b1 && bus.VALID_OUT === 1'b1) begin
      check("sb_nonempty", {71'h0, exp_q.size() != 0}, 72'h1);
      if (exp_q.size() != 0)
        check("sb_result", {4'h0, bus.RESULT, bus.RESULT_HI, bus.FLAGS, bus.DEST_OUT, bus.PC_OUT},
              {4'h0, exp_q.pop_front()});
    end
  end

  int n;

  initial begin
    RST = 1'b0;
    idle();
    bus.FUNC_CODE = '0; bus.EXECUTION = '0; bus.VALUE1 = '0; bus.VALUE2 = '0;
    bus.IMMEDIATE = '0; bus.OP1_ADDRESS = '0; bus.PROGRAM_COUNTER = '0;
    tick(2);
    check("reset_outputs", {2'b0, bus.RESULT, bus.RESULT_HI, bus.FLAGS, bus.DEST_OUT, bus.PC_OUT,
                            bus.VALID_OUT, bus.STALL}, 72'h0);
    check("reset_state", {70'h0, dbg_state}, 72'h0);
    RST = 1'b1;

    // reset asserted mid-MUL takes effect without a clock edge
    drive(4'd11, 1'b0, 16'h0003, 16'h0004, 16'h0, 16'h0011, 16'h0022, 1'b0);
    tick(1);
    idle();
    check("mul_busy", {71'h0, bus.STALL}, 72'h1);
    tick(4);
    #2 RST = 1'b0;
    #1;
    check("async_reset", {2'b0, bus.RESULT, bus.RESULT_HI, bus.FLAGS, bus.DEST_OUT, bus.PC_OUT,
                          bus.VALID_OUT, bus.STALL}, 72'h0);
    check("async_reset_state", {70'h0, dbg_state}, 72'h0);
    tick(1);
    RST = 1'b1;

    drive(4'd0, 1'b0, 16'h0005, 16'h0003, 16'h0, 16'h0001, 16'h0010, 1'b1);
    tick(1);
    idle();
    check("add_after_reset", {52'h0, bus.RESULT, bus.FLAGS}, {52'h0, 16'h0008, 4'b0000});
    tick(1);
    check("valid_one_cycle", {71'h0, bus.VALID_OUT}, 72'h0);

    // back-to-back ALU sweep
    drive(4'd0,  1'b0, 16'h7FFF, 16'h0001, 16'h0,    16'h0002, 16'h0020, 1'b1); tick(1);
    drive(4'd1,  1'b0, 16'h0000, 16'h0001, 16'h0,    16'h0003, 16'h0021, 1'b1); tick(1);
    drive(4'd8,  1'b0, 16'h8000, 16'h0004, 16'h0,    16'h0004, 16'h0022, 1'b1); tick(1);
    drive(4'd10, 1'b0, 16'h0001, 16'h0001, 16'h0,    16'h0005, 16'h0023, 1'b1); tick(1);
    drive(4'd14, 1'b0, 16'hFFFF, 16'h0001, 16'h0,    16'h0006, 16'h0024, 1'b1); tick(1);
    drive(4'd0,  1'b1, 16'h0001, 16'h5555, 16'h0010, 16'h0007, 16'h0025, 1'b1); tick(1);
    drive(4'd2,  1'b0, 16'hF0F0, 16'h3C3C, 16'h0,    16'h0008, 16'h0026, 1'b1); tick(1);
    drive(4'd3,  1'b0, 16'hF0F0, 16'h0F0F, 16'h0,    16'h0009, 16'h0027, 1'b1); tick(1);
    drive(4'd4,  1'b0, 16'hAAAA, 16'hAAAA, 16'h0,    16'h000A, 16'h0028, 1'b1); tick(1);
    drive(4'd5,  1'b0, 16'h00FF, 16'h0000, 16'h0,    16'h000B, 16'h0029, 1'b1); tick(1);
    drive(4'd6,  1'b0, 16'h0003, 16'h0005, 16'h0,    16'h000C, 16'h002A, 1'b1); tick(1);
    drive(4'd7,  1'b0, 16'h8000, 16'h000F, 16'h0,    16'h000D, 16'h002B, 1'b1); tick(1);
    drive(4'd9,  1'b0, 16'h8001, 16'h0003, 16'h0,    16'h000E, 16'h002C, 1'b1); tick(1);
    drive(4'd13, 1'b1, 16'h1111, 16'h2222, 16'hBEEF, 16'h000F, 16'h002D, 1'b1); tick(1);
    drive(4'd1,  1'b0, 16'h8000, 16'h0001, 16'h0,    16'h0010, 16'h002E, 1'b1); tick(1);
    drive(4'd15, 1'b0, 16'h1234, 16'h5678, 16'h0,    16'h0011, 16'h002F, 1'b1); tick(1);
    idle();
    tick(2);

    // MUL FFFF*FFFF with inputs disturbed after accept
    drive(4'd11, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h00A5, 16'h0100, 1'b1);
    tick(1);
    idle();
    bus.VALUE1 = 16'h1357; bus.VALUE2 = 16'h2468; bus.OP1_ADDRESS = 16'h0F0F; bus.PROGRAM_COUNTER = 16'hDEAD;
    wait_stall(n);
    check("mul_stall_cycles", 72'(n), 72'd16);
    check("mul_result", {3'b0, bus.VALID_OUT, bus.RESULT, bus.RESULT_HI, bus.FLAGS, bus.DEST_OUT, bus.PC_OUT},
          {3'b0, 1'b1, 16'h0001, 16'hFFFE, 4'b0011, 16'h00A5, 16'h0100});
    tick(1);
    check("mul_valid_pulse", {71'h0, bus.VALID_OUT}, 72'h0);

    // DIV nonzero and divide-by-zero
    drive(4'd12, 1'b0, 16'h1234, 16'h0010, 16'h0, 16'h0031, 16'h0200, 1'b1);
    tick(1);
    idle();
    wait_stall(n);
    check("div_stall_cycles", 72'(n), 72'd16);
    check("div_result", {40'h0, bus.RESULT, bus.RESULT_HI}, {40'h0, 16'h0123, 16'h0004});
    tick(1);
    drive(4'd12, 1'b0, 16'h1234, 16'h0000, 16'h0, 16'h0032, 16'h0201, 1'b1);
    tick(1);
    idle();
    check("div0_single_cycle", {70'h0, bus.STALL, bus.VALID_OUT}, {70'h0, 1'b0, 1'b1});
    tick(2);

    // ADD held on VALID_IN during a MUL is taken right after STALL falls
    drive(4'd11, 1'b0, 16'h0003, 16'h0005, 16'h0, 16'h0041, 16'h0300, 1'b1);
    tick(1);
    drive(4'd0, 1'b0, 16'h0100, 16'h0022, 16'h0, 16'h0042, 16'h0301, 1'b1);
    wait_stall(n);
    check("hold_stall_cycles", 72'(n), 72'd16);
    check("hold_mul_out", {55'h0, bus.VALID_OUT, bus.RESULT}, {55'h0, 1'b1, 16'h000F});
    tick(1);
    idle();
    check("hold_add_next", {55'h0, bus.VALID_OUT, bus.RESULT}, {55'h0, 1'b1, 16'h0122});
    tick(1);

    // FLUSH on the 8th DIV iteration discards the op
    drive(4'd0, 1'b0, 16'h0001, 16'h0001, 16'h0, 16'h0051, 16'h0400, 1'b1);
    tick(1);
    drive(4'd12, 1'b0, 16'h1234, 16'h0007, 16'h0, 16'h0052, 16'h0401, 1'b0);
    tick(1);
    idle();
    tick(7);
    check("flush_pre_busy", {71'h0, bus.STALL}, 72'h1);
    bus.FLUSH = 1'b1;
    tick(1);
    bus.FLUSH = 1'b0;
    check("flush_drop", {2'b0, bus.STALL, bus.VALID_OUT, bus.RESULT, bus.RESULT_HI, bus.DEST_OUT, bus.PC_OUT, 4'h0},
          {2'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0051, 16'h0400, 4'h0});
    check("flush_idle_state", {70'h0, dbg_state}, 72'h0);
    for (int i = 0; i < 20; i++) begin
      check("flush_no_valid", {71'h0, bus.VALID_OUT}, 72'h0);
      tick(1);
    end

    // FLUSH coincident with VALID_IN in IDLE blocks the accept
    drive(4'd0, 1'b0, 16'h0040, 16'h0040, 16'h0, 16'h0061, 16'h0500, 1'b0);
    bus.FLUSH = 1'b1;
    tick(1);
    idle();
    check("flush_idle_reject", {55'h0, bus.VALID_OUT, bus.RESULT}, {55'h0, 1'b0, 16'h0002});
    drive(4'd1, 1'b0, 16'h8000, 16'h0001, 16'h0, 16'h0062, 16'h0501, 1'b1);
    tick(1);
    idle();
    tick(3);

    check("sb_drained", 72'(exp_q.size()), 72'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute stage of the 16-bit pipeline, directly downstream of the ID/EX pipeline buffer. It consumes the buffered operands, function code and execution control word, and computes single-cycle ALU results or multi-cycle unsigned multiply/divide results. Results are registered for the EX/MEM buffer, and STALL back-pressures the ID/EX buffer while a multi-cycle operation is in flight.

## Interface
- WIDTH, 16, datapath width; all ops below are defined for 16.
- ITER, 16, multiply/divide iteration count (= WIDTH).
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- VALID_IN  in  1  ID/EX buffer holds a valid instruction.
- FLUSH  in  1  synchronous abort of the in-flight op (branch mispredict).
- FUNC_CODE  in  WIDTH  op select; only [3:0] decoded.
- EXECUTION  in  WIDTH  control word; bit0 = operand-B select (0 VALUE2, 1 IMMEDIATE); bits above 0 ignored.
- VALUE1  in  WIDTH  operand A.
- VALUE2  in  WIDTH  register operand B.
- IMMEDIATE  in  WIDTH  sign-extended immediate operand B.
- OP1_ADDRESS  in  WIDTH  destination register tag, passed through.
- PROGRAM_COUNTER  in  WIDTH  PC, passed through.
- RESULT  out  WIDTH  primary result (low product / quotient).
- RESULT_HI  out  WIDTH  high product / remainder; 0 for single-cycle ops.
- FLAGS  out  4  {Z,N,C,V}.
- DEST_OUT  out  WIDTH  registered OP1_ADDRESS of the completed op.
- PC_OUT  out  WIDTH  registered PROGRAM_COUNTER of the completed op.
- VALID_OUT  out  1  one-cycle pulse: outputs hold a new result.
- STALL  out  1  registered busy flag; upstream must freeze while high.

## Operation
- Accept = VALID_IN & ~STALL & ~FLUSH, sampled at the rising edge. B = EXECUTION[0] ? IMMEDIATE : VALUE2.
- FUNC_CODE[3:0]:
  - 0 ADD: C = carry out, V = signed overflow.
  - 1 SUB (A-B): C = borrow, V = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SLL, 7 SRL, 8 SRA, 9 ROL, 10 ROR: amount = B[3:0].
  - 11 MUL: unsigned, 32-bit product, shift-add.
  - 12 DIV: unsigned, restoring.
  - 13 PASS B.
  - 14 SLT: signed, result 1 if A<B else 0.
  - 15 NOP: RESULT 0, still produces VALID_OUT.
- C and V are 0 for all ops except ADD, SUB, MUL and DIV.
- Z = (RESULT==0), N = RESULT[15] for all ops.
- MUL: C = V = (RESULT_HI != 0).
- DIV: V = divide-by-zero; C = 0.
- Divide by zero: completes in one cycle; RESULT = 16'hFFFF, RESULT_HI = A.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL/DIV on accept of op 11/12 with a nonzero divisor.
  - MUL/DIV -> IDLE after ITER iterations, or on FLUSH.
- Operands, DEST and PC are latched at accept; later input changes do not affect the in-flight op.
- FLUSH:
  - In MUL/DIV: return to IDLE, clear STALL, no VALID_OUT.
  - In IDLE: the coincident instruction is not accepted.
  - FLUSH overrides completion on the same edge.
- VALID_IN while STALL is high is ignored; upstream holds the instruction until STALL falls.

## Timing
- Reset values: RESULT, RESULT_HI, DEST_OUT, PC_OUT = 0; FLAGS = 4'b0000; VALID_OUT = 0; STALL = 0; FSM = IDLE.
- Single-cycle op accepted at edge k:
  - All outputs update at edge k.
  - VALID_OUT is high in cycle k..k+1 only.
  - A new accept is possible at edge k+1 (throughput 1/cycle).
- MUL/DIV accepted at edge k:
  - STALL rises at edge k.
  - Iterations occur at edges k+1..k+16.
  - Outputs update and STALL falls at edge k+16.
  - VALID_OUT is high in cycle k+16..k+17.
  - The earliest next accept is edge k+17.
- VALID_OUT stays low except for single result pulses; outputs hold their value between results.
- RST asserted mid-operation immediately returns all state and outputs to their reset values, independent of CLK.

## Test plan
- Reset: RST low mid-MUL -> all outputs 0 and STALL 0 at once; after release, ADD 5+3 -> RESULT 8, FLAGS 0000, VALID_OUT for one cycle.
- ALU sweep, back-to-back one op per cycle:
  - ADD 7FFF+0001 -> 8000, FLAGS N,V = 0101.
  - SUB 0000-0001 -> FFFF, N,C.
  - SRA 8000 by 4 -> F800.
  - ROR 0001 by 1 -> 8000.
  - SLT FFFF<0001 -> 1.
  - EXECUTION[0]=1 selects IMMEDIATE.
- MUL FFFF*FFFF:
  - STALL high for exactly 16 cycles.
  - RESULT 0001, RESULT_HI FFFE, C=V=1.
  - VALID_OUT is one pulse at the 16th edge after accept; DEST_OUT and PC_OUT match the accepted values.
- DIV:
  - 1234/0010 -> RESULT 0123, RESULT_HI 0004 after 16 cycles.
  - 1234/0000 -> RESULT FFFF, RESULT_HI 1234, V=1, single-cycle, no STALL.
- Stall hold: VALID_IN held with a new ADD during a MUL -> ADD is ignored until STALL falls, then accepted at the next edge; its result follows the MUL result by exactly one cycle.
- FLUSH at iteration 8 of a DIV:
  - STALL drops at that edge; no VALID_OUT; outputs keep their prior values.
  - A FLUSH coincident with VALID_IN in IDLE -> instruction not accepted.
